// File: rtl/vexriscv_axi_pkg.sv
// Shared types and AXI constants for the VexRiscv dBus to AXI4 bridge.
// size_to_len maps a dBus log2 transfer size onto an AXI INCR burst length.
package vexriscv_axi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_WR_XFER,
        ST_WR_RESP
    } state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] RESP_OKAY      = 2'b00;

    // Transfers of one word or less still occupy a full 32-bit beat.
    function automatic logic [7:0] size_to_len(input logic [2:0] size);
        logic [7:0] beats;
        if (size <= 3'd2) begin
            beats = 8'd1;
        end else begin
            beats = 8'd1 << (size - 3'd2);
        end
        return beats - 8'd1;
    endfunction

endpackage

// File: rtl/vexriscv_dbus_axi_bridge_if.sv
// Bundles the VexRiscv dBus cmd/rsp channel and the AXI4 master channels.
// The master modport is the bridge's view; slave is the core plus memory side.
interface vexriscv_dbus_axi_bridge_if #(
    parameter int ADDR_W = 64
);
    logic              dbus_cmd_valid;
    logic              dbus_cmd_ready;
    logic              dbus_cmd_wr;
    logic [31:0]       dbus_cmd_address;
    logic [31:0]       dbus_cmd_data;
    logic [3:0]        dbus_cmd_mask;
    logic [2:0]        dbus_cmd_size;
    logic              dbus_cmd_last;
    logic              dbus_rsp_valid;
    logic              dbus_rsp_last;
    logic [31:0]       dbus_rsp_data;
    logic              dbus_rsp_error;

    logic              m_axi_awvalid;
    logic              m_axi_awready;
    logic [ADDR_W-1:0] m_axi_awaddr;
    logic [7:0]        m_axi_awlen;
    logic [2:0]        m_axi_awsize;
    logic [1:0]        m_axi_awburst;
    logic              m_axi_wvalid;
    logic              m_axi_wready;
    logic [31:0]       m_axi_wdata;
    logic [3:0]        m_axi_wstrb;
    logic              m_axi_wlast;
    logic              m_axi_bvalid;
    logic              m_axi_bready;
    logic [1:0]        m_axi_bresp;
    logic              m_axi_arvalid;
    logic              m_axi_arready;
    logic [ADDR_W-1:0] m_axi_araddr;
    logic [7:0]        m_axi_arlen;
    logic [2:0]        m_axi_arsize;
    logic [1:0]        m_axi_arburst;
    logic              m_axi_rvalid;
    logic              m_axi_rready;
    logic [31:0]       m_axi_rdata;
    logic [1:0]        m_axi_rresp;
    logic              m_axi_rlast;

    modport master (
        input  dbus_cmd_valid, dbus_cmd_wr, dbus_cmd_address, dbus_cmd_data,
               dbus_cmd_mask, dbus_cmd_size, dbus_cmd_last,
        output dbus_cmd_ready, dbus_rsp_valid, dbus_rsp_last, dbus_rsp_data, dbus_rsp_error,
        output m_axi_awvalid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
        input  m_axi_awready,
        output m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast,
        input  m_axi_wready,
        input  m_axi_bvalid, m_axi_bresp,
        output m_axi_bready,
        output m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
        input  m_axi_arready,
        input  m_axi_rvalid, m_axi_rdata, m_axi_rresp, m_axi_rlast,
        output m_axi_rready
    );

    modport slave (
        output dbus_cmd_valid, dbus_cmd_wr, dbus_cmd_address, dbus_cmd_data,
               dbus_cmd_mask, dbus_cmd_size, dbus_cmd_last,
        input  dbus_cmd_ready, dbus_rsp_valid, dbus_rsp_last, dbus_rsp_data, dbus_rsp_error,
        input  m_axi_awvalid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
        output m_axi_awready,
        input  m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast,
        output m_axi_wready,
        output m_axi_bvalid, m_axi_bresp,
        input  m_axi_bready,
        input  m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
        output m_axi_arready,
        output m_axi_rvalid, m_axi_rdata, m_axi_rresp, m_axi_rlast,
        input  m_axi_rready
    );

endinterface

// File: rtl/vexriscv_dbus_axi_bridge.sv
// Single-outstanding bridge from the VexRiscv data-cache dBus to an AXI4 master,
// with low-address relocation onto a host buffer base.
module vexriscv_dbus_axi_bridge
    import vexriscv_axi_pkg::*;
#(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 32,
    parameter int BEAT_CNT_W = 6
) (
    input  logic                ap_clk,
    input  logic                ap_rst_n,
    input  logic [31:0]         abs_address_i,
    input  logic [ADDR_W-1:0]   base_offset_i,
    output logic                busy_o,
    vexriscv_dbus_axi_bridge_if.master bus
);

    state_e                  state_q;
    logic [ADDR_W-1:0]       addr_q;
    logic [ADDR_W-1:0]       addr_d;
    logic [7:0]              len_q;
    logic [BEAT_CNT_W-1:0]   wCnt_q;
    logic                    awDone_q;
    logic                    wDone_q;
    logic                    rspValid_q;
    logic                    rspLast_q;
    logic                    rspError_q;
    logic [DATA_W-1:0]       rspData_q;

    logic awValid;
    logic wValid;
    logic wLast;
    logic awFire;
    logic wFire;
    logic unused_ok;

    // Addresses above the threshold already point into device space.
    assign addr_d = (bus.dbus_cmd_address > abs_address_i)
                  ? ADDR_W'(bus.dbus_cmd_address)
                  : base_offset_i + ADDR_W'(bus.dbus_cmd_address);

    assign awValid = (state_q == ST_WR_XFER) && !awDone_q;
    assign wValid  = (state_q == ST_WR_XFER) && !wDone_q && bus.dbus_cmd_valid;
    assign wLast   = (8'(wCnt_q) == len_q);
    assign awFire  = awValid && bus.m_axi_awready;
    assign wFire   = wValid && bus.m_axi_wready;

    assign bus.dbus_cmd_ready = ((state_q == ST_IDLE) && bus.dbus_cmd_valid && !bus.dbus_cmd_wr)
                              || ((state_q == ST_WR_XFER) && !wDone_q && bus.m_axi_wready);
    assign bus.dbus_rsp_valid = rspValid_q;
    assign bus.dbus_rsp_last  = rspLast_q;
    assign bus.dbus_rsp_data  = rspData_q;
    assign bus.dbus_rsp_error = rspError_q;

    assign bus.m_axi_awvalid = awValid;
    assign bus.m_axi_awaddr  = addr_q;
    assign bus.m_axi_awlen   = len_q;
    assign bus.m_axi_awsize  = AXI_SIZE_4B;
    assign bus.m_axi_awburst = AXI_BURST_INCR;
    assign bus.m_axi_wvalid  = wValid;
    assign bus.m_axi_wdata   = bus.dbus_cmd_data;
    assign bus.m_axi_wstrb   = bus.dbus_cmd_mask;
    assign bus.m_axi_wlast   = wLast;
    assign bus.m_axi_bready  = (state_q == ST_WR_RESP);
    assign bus.m_axi_arvalid = (state_q == ST_RD_ADDR);
    assign bus.m_axi_araddr  = addr_q;
    assign bus.m_axi_arlen   = len_q;
    assign bus.m_axi_arsize  = AXI_SIZE_4B;
    assign bus.m_axi_arburst = AXI_BURST_INCR;
    assign bus.m_axi_rready  = (state_q == ST_RD_DATA);

    assign busy_o = (state_q != ST_IDLE);

    // The core's own last flag is advisory; burst framing comes from wCnt_q.
    assign unused_ok = ^{bus.dbus_cmd_last, bus.m_axi_rresp[0], bus.m_axi_bresp[0]};

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            wCnt_q     <= '0;
            awDone_q   <= 1'b0;
            wDone_q    <= 1'b0;
            rspValid_q <= 1'b0;
            rspLast_q  <= 1'b0;
            rspError_q <= 1'b0;
            rspData_q  <= '0;
        end else begin
            rspValid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.dbus_cmd_valid) begin
                        addr_q   <= addr_d;
                        len_q    <= size_to_len(bus.dbus_cmd_size);
                        wCnt_q   <= '0;
                        awDone_q <= 1'b0;
                        wDone_q  <= 1'b0;
                        state_q  <= bus.dbus_cmd_wr ? ST_WR_XFER : ST_RD_ADDR;
                    end
                end
                ST_RD_ADDR: begin
                    if (bus.m_axi_arready) begin
                        state_q <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (bus.m_axi_rvalid) begin
                        rspValid_q <= 1'b1;
                        rspData_q  <= bus.m_axi_rdata;
                        rspLast_q  <= bus.m_axi_rlast;
                        rspError_q <= bus.m_axi_rresp[1];
                        if (bus.m_axi_rlast) begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_WR_XFER: begin
                    if (awFire) begin
                        awDone_q <= 1'b1;
                    end
                    if (wFire) begin
                        wCnt_q <= wCnt_q + BEAT_CNT_W'(1);
                        if (wLast) begin
                            wDone_q <= 1'b1;
                        end
                    end
                    if ((awDone_q || awFire) && (wDone_q || (wFire && wLast))) begin
                        state_q <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (bus.m_axi_bvalid) begin
                        rspValid_q <= 1'b1;
                        rspData_q  <= '0;
                        rspLast_q  <= 1'b1;
                        rspError_q <= bus.m_axi_bresp[1];
                        state_q    <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
